// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter for sll/srl/sra/rotr: moves the work register one bit per clock
// and raises done for a single cycle once the requested amount has been applied.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_t;

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   w_shifted;

    always_comb begin
        // NOTE: assign a default before the case so no path leaves w_shifted unassigned (no latch).
        w_shifted = r_work;
        case (r_op)
            OP_SLL:  w_shifted = {r_work[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, r_work[WIDTH-1:1]};
            OP_SRA:  w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            OP_ROTR: w_shifted = {r_work[0], r_work[WIDTH-1:1]};
            default: w_shifted = r_work;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_SLL;
            r_work  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_state <= S_IDLE;
                    // A start in the done cycle is taken just like one in idle.
                    if (start) begin
                        r_work <= operand;
                        r_cnt  <= shamt;
                        r_op   <= op_t'(op);
                        if (shamt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_work;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: table of shift vectors with a result scoreboard,
// plus hand-driven back-to-back and mid-operation reset sequences.
module tb_seq_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        bit          poke;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch in the current cycle (cycle 0), wait for done, return positioned in the done cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [4:0] s, input bit poke, input logic [31:0] e);
        int c;
        int busy_n;
        bit got;
        logic [31:0] exp_res;
        start = 1'b1; op = o; operand = x; shamt = s;
        sb_q.push_back(e);
        c = 0; busy_n = 0; got = 1'b0;
        while (!got && c < 40) begin
            @(posedge clk); #1;
            c++;
            start = poke && (c == 2);
            if (start) begin
                op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd1;
            end else begin
                op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
            end
            if (busy) busy_n++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({name, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, 32'(c), 32'(s) + 32'd1);
            check({name, " busy_cycles"}, 32'(busy_n), 32'(s));
            if (sb_q.size() == 0) begin
                check({name, " scoreboard_nonempty"}, 32'd0, 32'd1);
            end else begin
                exp_res = sb_q.pop_front();
                check({name, " result"}, result, exp_res);
            end
        end
    endtask

    task automatic idle_check(input string name, input logic [31:0] e);
        @(posedge clk); #1;
        check({name, " done_low_after"}, 32'(done), 32'd0);
        check({name, " busy_low_after"}, 32'(busy), 32'd0);
        check({name, " result_held"}, result, e);
    endtask

    initial begin
        int done_n;
        vecs[0]  = '{2'b00, 32'h0000_0001, 5'd2,  1'b0, 32'h0000_0004};
        vecs[1]  = '{2'b01, 32'h1234_5678, 5'd4,  1'b0, 32'h0123_4567};
        vecs[2]  = '{2'b10, 32'hFAAA_BBBB, 5'd8,  1'b0, 32'hFFFA_AABB};
        vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{2'b10, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF};
        vecs[8]  = '{2'b11, 32'h0000_0001, 5'd1,  1'b0, 32'h8000_0000};
        vecs[9]  = '{2'b00, 32'h0000_0001, 5'd5,  1'b1, 32'h0000_0020};
        vecs[10] = '{2'b00, 32'h8000_0001, 5'd31, 1'b0, 32'h8000_0000};
        vecs[11] = '{2'b11, 32'h1234_5678, 5'd8,  1'b0, 32'h7812_3456};
        vecs[12] = '{2'b01, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001};
        vecs[13] = '{2'b10, 32'h4000_0000, 5'd3,  1'b0, 32'h0800_0000};

        reset = 1'b1; start = 1'b0; op = 2'b00; operand = 32'h0; shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].operand, vecs[i].shamt,
                   vecs[i].poke, vecs[i].exp);
            idle_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-to-back: second start is driven in the first op's done cycle.
        run_op("b2b_first", 2'b00, 32'h0000_0001, 5'd2, 1'b0, 32'h0000_0004);
        run_op("b2b_second", 2'b01, 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000);
        idle_check("b2b_second", 32'h0F00_0000);

        // Reset in cycle 2 of a shamt=10 operation.
        start = 1'b1; op = 2'b00; operand = 32'h0000_0003; shamt = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'h0);
        done_n = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) done_n++;
        end
        check("abort no_done_pulse", 32'(done_n), 32'd0);
        check("abort result_stays_zero", result, 32'h0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
